// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with standard or first-word-fall-through read, live level and almost flags.
// Defining SYNC_FIFO_ERR_FLAG_EN adds sticky overflow/underflow outputs.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 9,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 508,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level
`ifdef SYNC_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int LW = DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L = LW'(ALMOST_FULL_NUM);
  localparam logic [LW-1:0] AE_L = LW'(ALMOST_EMPTY_NUM);
  if (DATA_WIDTH < 1 || DATA_WIDTH > 1152) begin : g_bad_dw
    $error("sync_fifo_fwft: DATA_WIDTH out of range 1..1152");
  end
  if (DEPTH_WIDTH < 2 || DEPTH_WIDTH > 20) begin : g_bad_aw
    $error("sync_fifo_fwft: DEPTH_WIDTH out of range 2..20");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_fwft: FWFT must be 0 or 1");
  end
  if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_af
    $error("sync_fifo_fwft: ALMOST_FULL_NUM out of range 1..2^DEPTH_WIDTH");
  end
  if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_fwft: ALMOST_EMPTY_NUM out of range 0..2^DEPTH_WIDTH-1");
  end
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, mcnt_q, mcnt_d;
  logic valid_q, valid_d, full_q, af_q, ae_q, empty_q, empty_d;
  logic wr_acc, rd_acc, mem_rd;
  // mcnt counts words still in memory; in FWFT mode the level also includes the prefetched word
  always_comb begin
    wr_acc = wr_en & ~full_q;
    rd_acc = rd_en & ~empty_q;
    mem_rd = (FWFT != 0) ? ((mcnt_q != '0) & (~valid_q | rd_acc)) : rd_acc;
    valid_d = mem_rd | (valid_q & ~rd_acc);
    level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    mcnt_d = mcnt_q + LW'(wr_acc) - LW'(mem_rd);
    wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(mem_rd);
    empty_d = (FWFT != 0) ? ~valid_d : (level_d == '0);
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else if (mem_rd) rd_data_q <= mem_q[rd_ptr_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      mcnt_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mcnt_q   <= mcnt_d;
      valid_q  <= valid_d;
      full_q   <= level_d == FULL_L;
      af_q     <= level_d >= AF_L;
      ae_q     <= level_d <= AE_L;
      empty_q  <= empty_d;
    end
  end
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q, unf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & full_q);
      unf_q <= unf_q | (rd_en & empty_q);
    end
  end
  assign overflow = ovf_q;
  assign underflow = unf_q;
`endif
  assign wr_full = full_q;
  assign almost_full = af_q;
  assign almost_empty = ae_q;
  assign rd_empty = empty_q;
  assign rd_data = rd_data_q;
  assign water_level = level_q;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: checks a standard-mode and an FWFT-mode FIFO (depth 16, thresholds 12/3) side by side
// against a queue-based reference model, a vector table and directed corner sequences.
module tb_sync_fifo_fwft;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic s_full, s_af, s_empty, s_ae, f_full, f_af, f_empty, f_ae;
  logic [15:0] s_rd, f_rd;
  logic [4:0] s_lvl, f_lvl;
`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic s_ovf, s_unf, f_ovf, f_unf;
`endif
  sync_fifo_fwft #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FWFT(0), .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(3)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full), .almost_full(s_af),
    .rd_en(rd_en), .rd_data(s_rd), .rd_empty(s_empty), .almost_empty(s_ae), .water_level(s_lvl)
`ifdef SYNC_FIFO_ERR_FLAG_EN
    , .overflow(s_ovf), .underflow(s_unf)
`endif
  );
  sync_fifo_fwft #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .FWFT(1), .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(3)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full), .almost_full(f_af),
    .rd_en(rd_en), .rd_data(f_rd), .rd_empty(f_empty), .almost_empty(f_ae), .water_level(f_lvl)
`ifdef SYNC_FIFO_ERR_FLAG_EN
    , .overflow(f_ovf), .underflow(f_unf)
`endif
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, ec = 0;
  logic [15:0] qs [$];
  logic [15:0] qf [$];
  int wf [$];
  logic [15:0] out_s = '0, out_f = '0;
  logic vis_f = 1'b0, ovf_s = 1'b0, unf_s = 1'b0, ovf_f = 1'b0, unf_f = 1'b0;
  typedef struct packed {
    logic rst; logic we; logic re; logic [15:0] wd;
    logic [4:0] lvl; logic full; logic empty; logic [15:0] rdd;
  } vec_t;
  vec_t tv [0:33];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, a, e, $time);
    end
  endtask
  // Reference: a word becomes visible in FWFT mode once it was written at an earlier edge than the current one.
  task automatic model_edge();
    logic rs, ws, rf, wa;
    ec++;
    if (rst) begin
      qs.delete(); qf.delete(); wf.delete();
      out_s = '0; out_f = '0; vis_f = 1'b0;
      ovf_s = 1'b0; unf_s = 1'b0; ovf_f = 1'b0; unf_f = 1'b0;
    end else begin
      ovf_s |= wr_en && qs.size() == 16; unf_s |= rd_en && qs.size() == 0;
      ovf_f |= wr_en && qf.size() == 16; unf_f |= rd_en && !vis_f;
      rs = rd_en && qs.size() != 0; ws = wr_en && qs.size() != 16;
      rf = rd_en && vis_f; wa = wr_en && qf.size() != 16;
      if (rs) out_s = qs.pop_front();
      if (ws) qs.push_back(wr_data);
      if (rf) begin void'(qf.pop_front()); void'(wf.pop_front()); end
      if (wa) begin qf.push_back(wr_data); wf.push_back(ec); end
      vis_f = qf.size() != 0 && wf[0] < ec;
      if (vis_f) out_f = qf[0];
    end
  endtask
  task automatic check_all();
    chk("s_lvl", 32'(s_lvl), 32'(qs.size()));
    chk("s_full", 32'(s_full), 32'(qs.size() == 16));
    chk("s_af", 32'(s_af), 32'(qs.size() >= 12));
    chk("s_ae", 32'(s_ae), 32'(qs.size() <= 3));
    chk("s_empty", 32'(s_empty), 32'(qs.size() == 0));
    chk("s_rd", 32'(s_rd), 32'(out_s));
    chk("f_lvl", 32'(f_lvl), 32'(qf.size()));
    chk("f_full", 32'(f_full), 32'(qf.size() == 16));
    chk("f_af", 32'(f_af), 32'(qf.size() >= 12));
    chk("f_ae", 32'(f_ae), 32'(qf.size() <= 3));
    chk("f_empty", 32'(f_empty), 32'(!vis_f));
    chk("f_rd", 32'(f_rd), 32'(out_f));
`ifdef SYNC_FIFO_ERR_FLAG_EN
    chk("s_ovf", 32'(s_ovf), 32'(ovf_s));
    chk("s_unf", 32'(s_unf), 32'(unf_s));
    chk("f_ovf", 32'(f_ovf), 32'(ovf_f));
    chk("f_unf", 32'(f_unf), 32'(unf_f));
`endif
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic drive(input logic r, input logic w, input logic rd, input logic [15:0] d);
    rst = r; wr_en = w; rd_en = rd; wr_data = d;
  endtask
  initial begin
    tv[0] = '{rst: 1'b1, we: 1'b0, re: 1'b0, wd: 16'h0, lvl: 5'd0, full: 1'b0, empty: 1'b1, rdd: 16'h0};
    for (int i = 1; i <= 16; i++)
      tv[i] = '{rst: 1'b0, we: 1'b1, re: 1'b0, wd: 16'(i), lvl: 5'(i), full: i == 16, empty: 1'b0, rdd: 16'h0};
    tv[17] = '{rst: 1'b0, we: 1'b1, re: 1'b0, wd: 16'hDEAD, lvl: 5'd16, full: 1'b1, empty: 1'b0, rdd: 16'h0};
    for (int k = 1; k <= 16; k++)
      tv[17+k] = '{rst: 1'b0, we: 1'b0, re: 1'b1, wd: 16'h0, lvl: 5'(16 - k), full: 1'b0, empty: k == 16, rdd: 16'(k)};
    for (int i = 0; i <= 33; i++) begin
      drive(tv[i].rst, tv[i].we, tv[i].re, tv[i].wd);
      step();
      chk("tv_lvl", 32'(s_lvl), 32'(tv[i].lvl));
      chk("tv_full", 32'(s_full), 32'(tv[i].full));
      chk("tv_empty", 32'(s_empty), 32'(tv[i].empty));
      chk("tv_rd", 32'(s_rd), 32'(tv[i].rdd));
`ifdef SYNC_FIFO_ERR_FLAG_EN
      if (i == 17) chk("tv_ovf", 32'(s_ovf), 32'd1);
`endif
    end
    drive(1, 0, 0, 0); step();
    drive(0, 1, 0, 16'h00A5); step();
    chk("fw_lat1_empty", 32'(f_empty), 32'd1);
    drive(0, 0, 0, 0); step();
    chk("fw_lat2_empty", 32'(f_empty), 32'd0);
    chk("fw_lat2_rd", 32'(f_rd), 32'h00A5);
    drive(0, 0, 1, 0); step();
    chk("fw_pop_empty", 32'(f_empty), 32'd1);
    chk("fw_pop_lvl", 32'(f_lvl), 32'd0);
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 8; i++) begin drive(0, 1, 0, 16'($urandom)); step(); end
    drive(0, 0, 0, 0); step(); step();
    for (int i = 0; i < 100; i++) begin
      drive(0, 1, 1, 16'($urandom)); step();
      chk("ss_s_lvl", 32'(s_lvl), 32'd8);
      chk("ss_f_lvl", 32'(f_lvl), 32'd8);
    end
    drive(1, 0, 0, 0); step();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 0, 16'(i)); step();
      chk("fill_ae", 32'(s_ae), 32'(i <= 3));
      chk("fill_af", 32'(s_af), 32'(i >= 12));
    end
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 1, 0); step();
      chk("drain_ae", 32'(s_ae), 32'(16 - k <= 3));
      chk("drain_af", 32'(s_af), 32'(16 - k >= 12));
    end
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 10; i++) begin drive(0, 1, 0, 16'(16'h0100 + i)); step(); end
    drive(1, 1, 1, 16'hBEEF); step();
    chk("rst_s_lvl", 32'(s_lvl), 32'd0);
    chk("rst_f_lvl", 32'(f_lvl), 32'd0);
    chk("rst_s_empty", 32'(s_empty), 32'd1);
    chk("rst_f_empty", 32'(f_empty), 32'd1);
    chk("rst_s_full", 32'(s_full), 32'd0);
    chk("rst_s_rd", 32'(s_rd), 32'd0);
    chk("rst_f_rd", 32'(f_rd), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAG_EN
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_unf", 32'(s_unf), 32'd0);
`endif
    drive(0, 1, 0, 16'h0077); step();
    drive(0, 0, 0, 0); step();
    chk("post_rst_f_rd", 32'(f_rd), 32'h0077);
    drive(0, 0, 1, 0); step();
    chk("post_rst_s_rd", 32'(s_rd), 32'h0077);
    chk("post_rst_s_empty", 32'(s_empty), 32'd1);
    drive(1, 0, 0, 0); step();
    drive(0, 1, 1, 16'h1234); step();
    chk("rw_empty_s_lvl", 32'(s_lvl), 32'd1);
    chk("rw_empty_f_lvl", 32'(f_lvl), 32'd1);
    chk("rw_empty_s_empty", 32'(s_empty), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAG_EN
    chk("rw_empty_unf", 32'(s_unf), 32'd1);
`endif
    for (int i = 0; i < 1500; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 80 : 25;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < 100 - pw, 16'($urandom));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Single-clock, parametrised successor to the dual-clock IP-wrapped FIFO used on the DDR read-data paths. It generalises data width and depth, and selects standard or first-word-fall-through read mode by parameter. It also exposes a live water level and programmable almost-full/almost-empty thresholds. It sits between same-clock producers and consumers in the video pipeline, e.g. line buffers and scaler input staging.

Parameters:
DATA_WIDTH, 16, width of wr_data/rd_data; legal range 1..1152
DEPTH_WIDTH, 9, log2 of depth; depth = 2^DEPTH_WIDTH; legal range 2..20
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = first-word-fall-through
ALMOST_FULL_NUM, 508, almost_full asserts when level >= this value; legal range 1..2^DEPTH_WIDTH
ALMOST_EMPTY_NUM, 4, almost_empty asserts when level <= this value; legal range 0..2^DEPTH_WIDTH-1

Ports:
clk  input  1  the single clock; all logic is on its rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
wr_full  output  1  FIFO full; writes are ignored while high
almost_full  output  1  level >= ALMOST_FULL_NUM
rd_en  input  1  read request (standard mode) / pop (FWFT mode)
rd_data  output  DATA_WIDTH  read data
rd_empty  output  1  no word available; reads are ignored while high
almost_empty  output  1  level <= ALMOST_EMPTY_NUM
water_level  output  DEPTH_WIDTH+1  number of stored words, 0..2^DEPTH_WIDTH

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. All outputs and flags are registered.
- Reset values: water_level=0, wr_full=0, almost_full=0 (1 if ALMOST_FULL_NUM=0 is ever permitted; it is not), rd_empty=1, almost_empty=1, rd_data=0. Pointers are 0.
- Reset mid-operation: all contents are discarded. A wr_en or rd_en in the reset cycle is ignored.
- Storage: 2^DEPTH_WIDTH x DATA_WIDTH memory array, written synchronously and read synchronously (block-RAM inferable).
- Pointers: binary wr_ptr and rd_ptr, DEPTH_WIDTH bits, wrap naturally 2^DEPTH_WIDTH-1 -> 0.
- Write accept: wr_acc = wr_en & ~wr_full. Read accept: rd_acc = rd_en & ~rd_empty. Both use flag values registered in the previous cycle.
- Simultaneous events:
  - Write while full is dropped, even if a read is accepted in the same cycle.
  - Read while empty is ignored; a same-cycle write is still accepted.
  - Accepted write and read together leave water_level unchanged.
- water_level: next = level + wr_acc - rd_acc. In FWFT mode the count includes the word held in the output register.
- Flags are derived from the next water_level, so they change in the same cycle as water_level:
  - wr_full = (level == 2^DEPTH_WIDTH)
  - almost_full = (level >= ALMOST_FULL_NUM)
  - almost_empty = (level <= ALMOST_EMPTY_NUM)
- Standard mode (FWFT=0):
  - rd_empty = (level == 0).
  - rd_acc at edge n: rd_data presents the word at edge n+1 and holds it until the next rd_acc.
  - A write into an empty FIFO at edge n gives rd_empty=0 after edge n+1.
- FWFT mode (FWFT=1):
  - An output register plus a valid bit prefetch the head word. rd_empty = ~valid. rd_data is valid whenever rd_empty=0.
  - rd_acc pops the word; the next word is shown on the following cycle with no bubble if memory holds one. Otherwise rd_empty rises.
  - A write into an empty FIFO at edge n gives rd_empty=0 after edge n+2 (one memory read plus the prefetch load).
  - Prefetch fires when (~valid | rd_acc) and memory is non-empty.
- Illegal parameter values stop elaboration with an $error in an initial/generate check.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAG_EN.
- When defined: two extra outputs, overflow and underflow, 1 bit each, reset 0.
  - overflow is set sticky by wr_en & wr_full; underflow is set sticky by rd_en & rd_empty.
  - Both are cleared only by rst.
- When undefined: these ports and their logic are absent, and attempted overflow/underflow is silently ignored.

Test Plan:
1. DEPTH_WIDTH=4, FWFT=0: write 16 words 0x0001..0x0010.
   - wr_full=1 and water_level=16 after the 16th edge.
   - A 17th write (0xDEAD) is dropped; overflow=1 if the macro is defined.
   - Read 16: rd_data 0x0001..0x0010 each one cycle after rd_en, then rd_empty=1.
2. FWFT=1, single write 0x00A5 at edge n:
   - rd_empty=0 and rd_data=0x00A5 after edge n+2.
   - rd_en pop -> rd_empty=1 next cycle, water_level=0.
3. Level 8, continuous simultaneous wr_en/rd_en for 100 cycles (both modes):
   - water_level stays 8.
   - Output sequence is the in-order input sequence.
   - Pointers wrap past 15 correctly.
4. DEPTH_WIDTH=4, ALMOST_FULL_NUM=12, ALMOST_EMPTY_NUM=3, filling 0->16 then draining:
   - almost_empty drops when level reaches 4.
   - almost_full rises when level reaches 12.
   - Both revert at the same thresholds while draining.
5. Reset while level=10 (rst=1 with wr_en=1, rd_en=1 for one cycle):
   - Next cycle: water_level=0, rd_empty=1, wr_full=0, rd_data=0, overflow/underflow=0.
   - A subsequent write/read returns only the new data.
6. Empty FIFO, rd_en=1 and wr_en=1 (0x1234) in the same cycle:
   - Write accepted, read ignored; water_level=1.
   - underflow=1 if the macro is defined.
